// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one fpu among NREQ requesters; sequences start/done and times out hung ops.
// state: IDLE accept | ISSUE start pulse | WAIT_CLR wait stale done low | WAIT_DONE wait done | RESP rsp pulse
module fpu_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [32*NREQ-1:0] req_b,
  input  logic [2*NREQ-1:0]  req_op,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [31:0]        rsp_r,
  output logic               rsp_err,
  output logic               busy,
  output logic [31:0]        fpu_a,
  output logic [31:0]        fpu_b,
  output logic [1:0]         fpu_op,
  output logic               fpu_start,
  input  logic [31:0]        fpu_r,
  input  logic               fpu_done
);
  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_CLR, S_WAIT_DONE, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0] gnt_oh_q, gnt_oh_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [31:0]     fpu_a_q, fpu_a_d, fpu_b_q, fpu_b_d;
  logic [1:0]      fpu_op_q, fpu_op_d;
  logic            fpu_start_q, fpu_start_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_r_q, rsp_r_d;
  logic            rsp_err_q, rsp_err_d;
  logic            busy_q, busy_d;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW:0]     cand;
  logic [NREQ-1:0] win_oh;
  logic [31:0]     sel_a, sel_b;
  logic [1:0]      sel_op;

  // Search begins one past the last winner and wraps, so every requester is reached within NREQ grants.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (!win_found && req_valid[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
    win_oh = '0;
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_found && win_idx == IW'(i)) begin
        win_oh[i] = 1'b1;
        sel_a     = req_a[32*i +: 32];
        sel_b     = req_b[32*i +: 32];
        sel_op    = req_op[2*i +: 2];
      end
    end
  end

  assign req_ready = (state_q == S_IDLE && !rst) ? win_oh : '0;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_oh_d    = gnt_oh_q;
    tmo_d       = tmo_q;
    fpu_a_d     = fpu_a_q;
    fpu_b_d     = fpu_b_q;
    fpu_op_d    = fpu_op_q;
    fpu_start_d = 1'b0;
    rsp_valid_d = '0;
    rsp_r_d     = rsp_r_q;
    rsp_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          rr_ptr_d = win_idx;
          gnt_oh_d = win_oh;
          fpu_a_d  = sel_a;
          fpu_b_d  = sel_b;
          fpu_op_d = sel_op;
          if (sel_op == 2'b11) begin
            state_d     = S_RESP;
            rsp_valid_d = win_oh;
            rsp_err_d   = 1'b1;
            rsp_r_d     = '0;
          end else begin
            state_d     = S_ISSUE;
            fpu_start_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT_CLR;
      end
      S_WAIT_CLR: begin
        // A done still high from the previous op is never taken as completion here.
        tmo_d = tmo_q + TW'(1);
        if (tmo_q == TMO_LAST) begin
          state_d     = S_RESP;
          rsp_valid_d = gnt_oh_q;
          rsp_err_d   = 1'b1;
          rsp_r_d     = '0;
        end else if (!fpu_done) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        tmo_d = tmo_q + TW'(1);
        if (fpu_done) begin
          state_d     = S_RESP;
          rsp_valid_d = gnt_oh_q;
          rsp_r_d     = fpu_r;
        end else if (tmo_q == TMO_LAST) begin
          state_d     = S_RESP;
          rsp_valid_d = gnt_oh_q;
          rsp_err_d   = 1'b1;
          rsp_r_d     = '0;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= IW'(NREQ - 1);
      gnt_oh_q    <= '0;
      tmo_q       <= '0;
      fpu_a_q     <= '0;
      fpu_b_q     <= '0;
      fpu_op_q    <= '0;
      fpu_start_q <= 1'b0;
      rsp_valid_q <= '0;
      rsp_r_q     <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_oh_q    <= gnt_oh_d;
      tmo_q       <= tmo_d;
      fpu_a_q     <= fpu_a_d;
      fpu_b_q     <= fpu_b_d;
      fpu_op_q    <= fpu_op_d;
      fpu_start_q <= fpu_start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_r_q     <= rsp_r_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  assign fpu_a     = fpu_a_q;
  assign fpu_b     = fpu_b_q;
  assign fpu_op    = fpu_op_q;
  assign fpu_start = fpu_start_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_r     = rsp_r_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter: fpu stand-in driven on negedge with configurable done timing.
module tb_fpu_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a, req_b;
  logic [7:0]   req_op;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_r;
  logic         rsp_err, busy;
  logic [31:0]  fpu_a, fpu_b;
  logic [1:0]   fpu_op;
  logic         fpu_start;
  logic [31:0]  fpu_r = '0;
  logic         fpu_done = 1'b0;

  int n_assert = 0;
  int n_fail = 0;

  // fpu stand-in: mode 0 normal, 1 stale done held two cycles past start, 2 hung
  int          mode = 0;
  int          mdelay = 2;
  logic [31:0] model_r = '0;
  int          mage = 0;
  bit          mact = 1'b0;

  fpu_arbiter #(.NREQ(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
    .rsp_r(rsp_r), .rsp_err(rsp_err), .busy(busy), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_op(fpu_op), .fpu_start(fpu_start), .fpu_r(fpu_r), .fpu_done(fpu_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fpu_start) begin
      mage = 0;
      mact = (mode != 2);
      if (mode != 1) fpu_done = 1'b0;
    end else if (mact) begin
      mage++;
      if (mode == 1 && mage == 2) fpu_done = 1'b0;
      if (mage == mdelay) begin
        fpu_done = 1'b1;
        fpu_r    = model_r;
        mact     = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(output int waited);
    waited = 0;
    #1;
    while (req_ready == '0 && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (req_ready == '0) chk("ready_wait_expired", 32'(req_ready != '0), 32'd1);
  endtask

  task automatic wait_rsp(input logic [3:0] drop, output int lat, output int starts,
                          output logic [31:0] a_seen);
    lat    = 0;
    starts = 0;
    a_seen = '0;
    do begin
      @(negedge clk);
      #1;
      lat++;
      if (lat == 1) req_valid = req_valid & ~drop;
      if (fpu_start) begin
        starts++;
        a_seen = fpu_a;
      end
    end while (rsp_valid == '0 && lat < 200);
    if (rsp_valid == '0) chk("rsp_wait_expired", 32'(rsp_valid != '0), 32'd1);
  endtask

  int          waited, lat, starts;
  logic [31:0] a_seen;
  int          order[5] = '{0, 1, 2, 3, 0};
  logic [31:0] a_tab[4] = '{32'h10000000, 32'h20000000, 32'h30000000, 32'h40000000};
  logic [31:0] r_tab[5] = '{32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004, 32'hA0000005};

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_r", rsp_r, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_fpu_start", 32'(fpu_start), 32'h0);
    chk("rst_fpu_a", fpu_a, 32'h0);
    chk("rst_fpu_op", 32'(fpu_op), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    rst = 1'b0;

    // all four requesters valid constantly, mult ops, done two cycles after start
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32] = a_tab[i];
      req_b[32*i +: 32] = 32'h3f800000;
      req_op[2*i +: 2]  = 2'b10;
    end
    mode = 0; mdelay = 2;
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      model_r = r_tab[k];
      wait_ready(waited);
      chk("rr_ready", 32'(req_ready), 32'(1) << order[k]);
      if (k > 0) chk("rr_gap", 32'(waited), 32'd1);
      wait_rsp(4'b0000, lat, starts, a_seen);
      chk("rr_latency", 32'(lat), 32'd4);
      chk("rr_starts", 32'(starts), 32'd1);
      chk("rr_fpu_a", a_seen, a_tab[order[k]]);
      chk("rr_rsp_valid", 32'(rsp_valid), 32'(1) << order[k]);
      chk("rr_rsp_r", rsp_r, r_tab[k]);
      chk("rr_rsp_err", 32'(rsp_err), 32'h0);
      chk("rr_no_ready_in_resp", 32'(req_ready), 32'h0);
    end
    req_valid = '0;

    // single add, done three cycles after start
    @(negedge clk);
    req_a[31:0] = 32'h3f800000; req_b[31:0] = 32'h40000000; req_op[1:0] = 2'b00;
    mode = 0; mdelay = 3; model_r = 32'h40400000;
    req_valid = 4'b0001;
    wait_ready(waited);
    chk("add_ready", 32'(req_ready), 32'h1);
    chk("add_ready_now", 32'(waited), 32'd0);
    wait_rsp(4'b0001, lat, starts, a_seen);
    chk("add_latency", 32'(lat), 32'd5);
    chk("add_starts", 32'(starts), 32'd1);
    chk("add_fpu_a", a_seen, 32'h3f800000);
    chk("add_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("add_rsp_r", rsp_r, 32'h40400000);
    chk("add_rsp_err", 32'(rsp_err), 32'h0);
    @(negedge clk);
    #1;
    chk("add_idle_busy", 32'(busy), 32'h0);
    chk("add_pulse_end", 32'(rsp_valid), 32'h0);

    // stale done: level still high from the add, drops two cycles after start
    req_a[31:0] = 32'h40400000; req_b[31:0] = 32'h3f800000; req_op[1:0] = 2'b01;
    mode = 1; mdelay = 5; model_r = 32'h12345678;
    req_valid = 4'b0001;
    wait_ready(waited);
    chk("stale_ready", 32'(req_ready), 32'h1);
    wait_rsp(4'b0001, lat, starts, a_seen);
    chk("stale_latency", 32'(lat), 32'd7);
    chk("stale_rsp_r", rsp_r, 32'h12345678);
    chk("stale_rsp_err", 32'(rsp_err), 32'h0);

    // hung fpu on req3: timeout 64 cycles after entering WAIT_CLR (accept + 2)
    @(negedge clk);
    req_a[127:96] = 32'h0000BEEF; req_op[7:6] = 2'b00;
    mode = 2;
    req_valid = 4'b1000;
    wait_ready(waited);
    chk("hung_ready", 32'(req_ready), 32'h8);
    wait_rsp(4'b1000, lat, starts, a_seen);
    chk("hung_latency", 32'(lat), 32'd66);
    chk("hung_rsp_valid", 32'(rsp_valid), 32'h8);
    chk("hung_rsp_err", 32'(rsp_err), 32'h1);
    chk("hung_rsp_r", rsp_r, 32'h0);

    // done arriving on the last timeout cycle wins
    @(negedge clk);
    req_a[63:32] = 32'h00001111; req_op[3:2] = 2'b10;
    mode = 0; mdelay = 64; model_r = 32'hCAFEF00D;
    req_valid = 4'b0010;
    wait_ready(waited);
    chk("edge_ready", 32'(req_ready), 32'h2);
    wait_rsp(4'b0010, lat, starts, a_seen);
    chk("edge_latency", 32'(lat), 32'd66);
    chk("edge_rsp_err", 32'(rsp_err), 32'h0);
    chk("edge_rsp_r", rsp_r, 32'hCAFEF00D);

    // illegal op on req2 responds next cycle without touching the fpu
    @(negedge clk);
    req_op[5:4] = 2'b11;
    req_valid = 4'b0100;
    wait_ready(waited);
    chk("ill_ready", 32'(req_ready), 32'h4);
    wait_rsp(4'b0100, lat, starts, a_seen);
    chk("ill_latency", 32'(lat), 32'd1);
    chk("ill_starts", 32'(starts), 32'd0);
    chk("ill_rsp_valid", 32'(rsp_valid), 32'h4);
    chk("ill_rsp_err", 32'(rsp_err), 32'h1);
    chk("ill_rsp_r", rsp_r, 32'h0);
    @(negedge clk);
    #1;
    chk("ill_no_start", 32'(fpu_start), 32'h0);

    // reset while in WAIT_DONE
    req_a[63:32] = 32'h0BAD0001; req_op[3:2] = 2'b00;
    mode = 2;
    req_valid = 4'b0010;
    wait_ready(waited);
    chk("rstop_ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rstop_busy", 32'(busy), 32'h1);
    chk("rstop_fpu_a", fpu_a, 32'h0BAD0001);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rstop_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rstop_fpu_start", 32'(fpu_start), 32'h0);
    chk("rstop_busy_low", 32'(busy), 32'h0);
    chk("rstop_fpu_a_low", fpu_a, 32'h0);
    chk("rstop_rsp_err", 32'(rsp_err), 32'h0);
    rst = 1'b0;
    mode = 0; mdelay = 2; model_r = 32'h5555AAAA;
    req_a[31:0] = 32'h70000000; req_op[1:0] = 2'b00;
    req_valid = 4'b0011;
    wait_ready(waited);
    chk("post_rst_ready0", 32'(req_ready), 32'h1);
    wait_rsp(4'b0001, lat, starts, a_seen);
    chk("post_rst_latency", 32'(lat), 32'd4);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("post_rst_rsp_r", rsp_r, 32'h5555AAAA);
    model_r = 32'h6666BBBB;
    wait_ready(waited);
    chk("post_rst_ready1", 32'(req_ready), 32'h2);
    wait_rsp(4'b0010, lat, starts, a_seen);
    chk("post_rst_fpu_a1", a_seen, 32'h0BAD0001);
    chk("post_rst_rsp_valid1", 32'(rsp_valid), 32'h2);
    chk("post_rst_rsp_r1", rsp_r, 32'h6666BBBB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
